bus_arbiter_nm: RTL

- Parametrised N-master, single-slave bus arbiter; successor to the current two-master memory controller.
- Latches the winning master's address, write flag and write data onto the shared peripheral bus (PADDR/PWRITE/PDATA) for a programmable number of wait cycles.
- Returns a one-cycle completion pulse to the winner and a per-master stall vector.
- Sits between pipeline/DMA masters and the ROM/RAM/UART/pin slaves, on the divided core clock.

---
 rtl/bus_arbiter_nm.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_nm.sv
// N-master, single-slave bus arbiter with programmable wait states.
// Fixed-priority or round-robin selection, one-cycle completion pulse.
module bus_arbiter_nm #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = 0,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                          CLK,
  input  logic                          HRESET,
  input  logic [NUM_MASTERS-1:0]        HTRANS,
  input  logic [NUM_MASTERS*ADDR_W-1:0] HADDR,
  input  logic [NUM_MASTERS-1:0]        HWRITE,
  input  logic [NUM_MASTERS*DATA_W-1:0] HWDATA,
  output logic [ADDR_W-1:0]             PADDR,
  output logic                          PWRITE,
  output logic [DATA_W-1:0]             PDATA,
  output logic                          PVALID,
  output logic [NUM_MASTERS-1:0]        HGRANT,
  output logic [NUM_MASTERS-1:0]        HREADY,
  output logic [NUM_MASTERS-1:0]        HSTALL,
  output logic                          stall
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] ready_q, ready_d;
  logic                   pvalid_q, pvalid_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]      paddr_q, paddr_d;
  logic [DATA_W-1:0]      pdata_q, pdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       win_q, win_d;

  logic [IDX_W-1:0]       base;
  logic [IDX_W-1:0]       k;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_found;

  assign base = (ARB_MODE == 1) ? ptr_q : '0;

  // Scan from base, wrapping; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    k         = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      k = IDX_W'((int'(base) + i) % NUM_MASTERS);
      if (!win_found && HTRANS[k]) begin
        win_found = 1'b1;
        win_idx   = k;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ready_d  = '0;
    pvalid_d = pvalid_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pdata_d  = pdata_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = ACCESS;
          win_d    = win_idx;
          grant_d  = NUM_MASTERS'(1) << win_idx;
          pvalid_d = 1'b1;
          pwrite_d = HWRITE[win_idx];
          paddr_d  = HADDR[win_idx*ADDR_W +: ADDR_W];
          pdata_d  = HWDATA[win_idx*DATA_W +: DATA_W];
          cnt_d    = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d        = DONE;
          ready_d[win_q] = 1'b1;
          grant_d        = '0;
          pvalid_d       = 1'b0;
          pwrite_d       = 1'b0;
          ptr_d          = (win_q == IDX_W'(NUM_MASTERS - 1))
                           ? '0 : win_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ready_q  <= '0;
      pvalid_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pdata_q  <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      pvalid_q <= pvalid_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pdata_q  <= pdata_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
    end
  end

  assign PADDR  = paddr_q;
  assign PDATA  = pdata_q;
  assign PVALID = pvalid_q;
  assign PWRITE = pwrite_q & pvalid_q;
  assign HGRANT = grant_q;
  assign HREADY = ready_q;
  assign HSTALL = HTRANS & ~ready_q;
  assign stall  = |HSTALL;

endmodule
